// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI receive-side frame decoder.
package spi_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SIZE,
        DATA,
        CSUM
    } state_t;

    typedef logic [15:0] word_t;

    // Word seen on the link when the SPI slave has nothing to say.
    localparam word_t      IDLE_WORD = 16'hFFFF;

    // Address that every decoder accepts.
    localparam logic [7:0] BROADCAST = 8'hFF;

endpackage

// File: rtl/frame_watchdog.sv
// Inter-word watchdog: counts idle cycles inside a frame and flags expiry
// once TIMEOUT cycles have elapsed since the last clear.
module frame_watchdog #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int           W     = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] r_count;

    // Count enabled cycles, holding at the limit until the next clear.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LIMIT)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign expired = enable && (r_count == LIMIT);

endmodule

// File: rtl/spi_frame_decoder.sv
// Receive-side SPI framer: parses header/size/payload/checksum frames from
// the SPI receive push bus, forwards addressed payload words downstream and
// reports per-frame status.
module spi_frame_decoder
    import spi_frame_pkg::*;
#(
    parameter logic [7:0] ADDR     = 8'h01,
    parameter int         MAX_SIZE = 32,
    parameter int         TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        nRst,
    // upstream push bus (SPI receive words)
    input  logic [15:0] inBus_data,
    input  logic        inBus_request,
    output logic        inBus_done,
    // downstream push bus (payload words)
    output logic [15:0] outBus_data,
    output logic        outBus_request,
    input  logic        outBus_done,
    // frame status
    output logic [7:0]  cmd,
    output logic        packetStart,
    output logic        packetEnd,
    output logic        packetOk,
    output logic [7:0]  errCount
);

    localparam word_t MAX_WORD = word_t'(MAX_SIZE);

    state_t     r_state;
    logic       r_match;
    word_t      r_sum;
    word_t      r_remain;
    logic       r_in_done;
    word_t      r_out_data;
    logic       r_out_req;
    logic [7:0] r_cmd;
    logic       r_start;
    logic       r_end;
    logic       r_ok;
    logic       r_end_pend;
    logic [7:0] r_err;

    logic       w_expired;
    logic       w_accept;
    logic       w_hdr_match;

    // A new word is taken only when the previous handshake has completed, the
    // output stage is free and no deferred abort status is waiting to go out.
    assign w_accept    = inBus_request && !r_in_done && !r_out_req &&
                         !r_end_pend && !w_expired;
    assign w_hdr_match = (inBus_data[15:8] == ADDR) || (inBus_data[15:8] == BROADCAST);

    frame_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .nRst    (nRst),
        .clear   (w_accept || w_expired || (r_state == IDLE)),
        .enable  (r_state != IDLE),
        .expired (w_expired)
    );

    // Frame parser, handshakes and registered status outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state    <= IDLE;
            r_match    <= 1'b0;
            r_sum      <= '0;
            r_remain   <= '0;
            r_in_done  <= 1'b0;
            r_out_data <= '0;
            r_out_req  <= 1'b0;
            r_cmd      <= '0;
            r_start    <= 1'b0;
            r_end      <= 1'b0;
            r_ok       <= 1'b0;
            r_end_pend <= 1'b0;
            r_err      <= '0;
        end else begin
            r_in_done <= w_accept;
            r_start   <= 1'b0;
            r_end     <= 1'b0;
            r_ok      <= 1'b0;

            if (r_out_req && outBus_done) begin
                r_out_req <= 1'b0;
            end

            // Abort status held back behind a payload word still in flight.
            if (r_end_pend && !r_out_req) begin
                r_end      <= 1'b1;
                r_end_pend <= 1'b0;
            end

            if (w_expired) begin
                r_state <= IDLE;
                if (r_match) begin
                    if (r_out_req) begin
                        r_end_pend <= 1'b1;
                    end else begin
                        r_end <= 1'b1;
                    end
                    if (r_err != 8'hFF) begin
                        r_err <= r_err + 8'd1;
                    end
                end
            end else if (w_accept) begin
                unique case (r_state)
                    IDLE: begin
                        if (inBus_data != IDLE_WORD) begin
                            r_state <= SIZE;
                            r_match <= w_hdr_match;
                            r_sum   <= inBus_data;
                            if (w_hdr_match) begin
                                r_cmd   <= inBus_data[7:0];
                                r_start <= 1'b1;
                            end
                        end
                    end
                    SIZE: begin
                        r_sum    <= r_sum + inBus_data;
                        r_remain <= inBus_data;
                        if (inBus_data > MAX_WORD) begin
                            r_state <= IDLE;
                            if (r_match) begin
                                r_end <= 1'b1;
                                if (r_err != 8'hFF) begin
                                    r_err <= r_err + 8'd1;
                                end
                            end
                        end else if (inBus_data == '0) begin
                            r_state <= CSUM;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        r_sum    <= r_sum + inBus_data;
                        r_remain <= r_remain - 16'd1;
                        if (r_match) begin
                            r_out_data <= inBus_data;
                            r_out_req  <= 1'b1;
                        end
                        if (r_remain == 16'd1) begin
                            r_state <= CSUM;
                        end
                    end
                    CSUM: begin
                        r_state <= IDLE;
                        if (r_match) begin
                            r_end <= 1'b1;
                            r_ok  <= (inBus_data == r_sum);
                            if ((inBus_data != r_sum) && (r_err != 8'hFF)) begin
                                r_err <= r_err + 8'd1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign inBus_done     = r_in_done;
    assign outBus_data    = r_out_data;
    assign outBus_request = r_out_req;
    assign cmd            = r_cmd;
    assign packetStart    = r_start;
    assign packetEnd      = r_end;
    assign packetOk       = r_ok;
    assign errCount       = r_err;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Self-checking bench for spi_frame_decoder: frames are built from their
// field values, and the expected payload stream, status events and error
// count are derived from the frame contents, not from the parser.
module tb_spi_frame_decoder;

    localparam logic [7:0] ADDR     = 8'h12;
    localparam int         MAX_SIZE = 32;
    localparam int         TIMEOUT  = 40;

    typedef int iq_t[$];

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [15:0] inBus_data = '0;
    logic        inBus_request = 1'b0;
    logic        inBus_done;
    logic [15:0] outBus_data;
    logic        outBus_request;
    logic        outBus_done = 1'b0;
    logic [7:0]  cmd;
    logic        packetStart;
    logic        packetEnd;
    logic        packetOk;
    logic [7:0]  errCount;

    spi_frame_decoder #(
        .ADDR     (ADDR),
        .MAX_SIZE (MAX_SIZE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .nRst           (nRst),
        .inBus_data     (inBus_data),
        .inBus_request  (inBus_request),
        .inBus_done     (inBus_done),
        .outBus_data    (outBus_data),
        .outBus_request (outBus_request),
        .outBus_done    (outBus_done),
        .cmd            (cmd),
        .packetStart    (packetStart),
        .packetEnd      (packetEnd),
        .packetOk       (packetOk),
        .errCount       (errCount)
    );

    always #5 clk = ~clk;

    int tx_q[$];
    int fixed_pay[$];
    int exp_out[$];
    int obs_out[$];
    int exp_evt[$];   // 'h100|cmd for packetStart, 'h200|ok for packetEnd
    int obs_evt[$];
    int exp_err = 0;
    int n_checks = 0;
    int n_fail = 0;
    int stall = 0;
    int stall_cnt = 0;
    int n_both = 0;
    int n_viol = 0;
    bit prev_out_req = 1'b0;

    function automatic int unsigned sig(input iq_t q);
        int unsigned s;
        s = 32'd17;
        foreach (q[i]) s = s * 32'd31 + int'(q[i]) + 32'd1;
        return s;
    endfunction

    // Downstream sink with programmable stall, plus status event recorder.
    always @(negedge clk) begin
        if (!nRst) begin
            outBus_done  = 1'b0;
            stall_cnt    = 0;
            prev_out_req = 1'b0;
        end else begin
            if (packetStart) obs_evt.push_back(32'h100 | int'(cmd));
            if (packetEnd)   obs_evt.push_back(32'h200 | int'(packetOk));
            if (packetStart && packetEnd) n_both++;
            if (inBus_done && prev_out_req) n_viol++;
            prev_out_req = outBus_request;
            if (outBus_request && !outBus_done) begin
                if (stall_cnt < stall) begin
                    stall_cnt++;
                end else begin
                    outBus_done = 1'b1;
                    obs_out.push_back(int'(outBus_data));
                    stall_cnt = 0;
                end
            end else begin
                outBus_done = 1'b0;
            end
        end
    end

    task automatic clear_q();
        tx_q.delete(); fixed_pay.delete();
        exp_out.delete(); obs_out.delete();
        exp_evt.delete(); obs_evt.delete();
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        int cyc;
        cyc = 0;
        @(negedge clk);
        inBus_data    = w;
        inBus_request = 1'b1;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!inBus_done && cyc < 3000);
        inBus_request = 1'b0;
        n_checks++;
        if (inBus_done !== 1'b1) begin
            n_fail++;
            $display("FAIL send_word %h: inBus_done=%b after %0d cycles, expected 1", w, inBus_done, cyc);
        end
    endtask

    task automatic send_all();
        while (tx_q.size() > 0) send_word(16'(tx_q.pop_front()));
    endtask

    // Builds one frame and records what an observer should see for it.
    task automatic add_frame(input logic [7:0] addr, input logic [7:0] c, input int n,
                             input bit corrupt, input bit use_fixed);
        logic [15:0] sum, w;
        bit          m;
        m = (addr == ADDR) || (addr == 8'hFF);
        w = {addr, c};
        tx_q.push_back(int'(w));
        sum = w;
        tx_q.push_back(n);
        sum = sum + 16'(n);
        if (m) exp_evt.push_back(32'h100 | int'(c));
        for (int i = 0; i < n; i++) begin
            w = use_fixed ? 16'(fixed_pay[i]) : 16'($urandom);
            tx_q.push_back(int'(w));
            sum = sum + w;
            if (m) exp_out.push_back(int'(w));
        end
        if (corrupt) sum = sum + 16'd1;
        tx_q.push_back(int'(sum));
        if (m) begin
            exp_evt.push_back(corrupt ? 32'h200 : 32'h201);
            if (corrupt && exp_err < 255) exp_err++;
        end
    endtask

    task automatic add_oversize(input logic [7:0] addr, input logic [7:0] c, input int n);
        bit m;
        m = (addr == ADDR) || (addr == 8'hFF);
        tx_q.push_back(int'({addr, c}));
        tx_q.push_back(n);
        if (m) begin
            exp_evt.push_back(32'h100 | int'(c));
            exp_evt.push_back(32'h200);
            if (exp_err < 255) exp_err++;
        end
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        settle(3);
        n_checks++;
        if ({inBus_done, outBus_request, packetStart, packetEnd, packetOk} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 00000",
                     {inBus_done, outBus_request, packetStart, packetEnd, packetOk});
        end
        n_checks++;
        if (outBus_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, expected 0000", outBus_data);
        end
        n_checks++;
        if ({cmd, errCount} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_status: cmd=%h errCount=%h, expected 00/00", cmd, errCount);
        end
        nRst = 1'b1;
        exp_err = 0;
        settle(2);
    endtask

    task automatic test_good_frame();
        clear_q();
        fixed_pay = '{32'hAAAA, 32'h5555};
        add_frame(8'h12, 8'h01, 2, 1'b0, 1'b1);
        send_all();
        settle(10);
        n_checks++;
        if (sig(obs_out) !== sig(exp_out)) begin
            n_fail++;
            $display("FAIL good_frame payload: got %0d words (sig %h), expected %0d words (sig %h)",
                     obs_out.size(), sig(obs_out), exp_out.size(), sig(exp_out));
        end
        n_checks++;
        if (sig(obs_evt) !== sig(exp_evt)) begin
            n_fail++;
            $display("FAIL good_frame status: got %0d events (sig %h), expected %0d (sig %h)",
                     obs_evt.size(), sig(obs_evt), exp_evt.size(), sig(exp_evt));
        end
        n_checks++;
        if (errCount !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL good_frame errCount: got %0d, expected %0d", errCount, exp_err);
        end
        $display("good_frame: %0d payload words, %0d status events", obs_out.size(), obs_evt.size());
    endtask

    task automatic test_bad_checksum();
        clear_q();
        fixed_pay = '{32'hAAAA, 32'h5555};
        add_frame(8'h12, 8'h01, 2, 1'b1, 1'b1);
        send_all();
        settle(10);
        n_checks++;
        if (sig(obs_out) !== sig(exp_out)) begin
            n_fail++;
            $display("FAIL bad_checksum payload: got %0d words (sig %h), expected %0d words (sig %h)",
                     obs_out.size(), sig(obs_out), exp_out.size(), sig(exp_out));
        end
        n_checks++;
        if (sig(obs_evt) !== sig(exp_evt)) begin
            n_fail++;
            $display("FAIL bad_checksum status: got %0d events (sig %h), expected %0d (sig %h)",
                     obs_evt.size(), sig(obs_evt), exp_evt.size(), sig(exp_evt));
        end
        n_checks++;
        if (errCount !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL bad_checksum errCount: got %0d, expected %0d", errCount, exp_err);
        end
        $display("bad_checksum: errCount=%0d", errCount);
    endtask

    task automatic test_address_filter();
        clear_q();
        fixed_pay = '{32'hBEEF};
        add_frame(8'h34, 8'h01, 1, 1'b0, 1'b1);
        add_frame(8'h12, 8'h01, 0, 1'b0, 1'b0);
        add_frame(8'hFF, 8'h05, 0, 1'b0, 1'b0);
        send_all();
        settle(10);
        n_checks++;
        if (sig(obs_out) !== sig(exp_out)) begin
            n_fail++;
            $display("FAIL addr_filter payload: got %0d words (sig %h), expected %0d words (sig %h)",
                     obs_out.size(), sig(obs_out), exp_out.size(), sig(exp_out));
        end
        n_checks++;
        if (sig(obs_evt) !== sig(exp_evt)) begin
            n_fail++;
            $display("FAIL addr_filter status: got %0d events (sig %h), expected %0d (sig %h)",
                     obs_evt.size(), sig(obs_evt), exp_evt.size(), sig(exp_evt));
        end
        $display("addr_filter: %0d status events", obs_evt.size());
    endtask

    task automatic test_oversize();
        clear_q();
        add_oversize(8'h12, 8'h01, MAX_SIZE + 1);
        add_frame(8'h12, 8'h07, 0, 1'b0, 1'b0);
        send_word(16'(tx_q.pop_front()));
        send_word(16'(tx_q.pop_front()));
        n_checks++;
        if ({packetEnd, packetOk} !== 2'b10) begin
            n_fail++;
            $display("FAIL oversize_end: packetEnd/packetOk=%b, expected 10 with size word done",
                     {packetEnd, packetOk});
        end
        send_all();
        settle(10);
        n_checks++;
        if (sig(obs_evt) !== sig(exp_evt)) begin
            n_fail++;
            $display("FAIL oversize status: got %0d events (sig %h), expected %0d (sig %h)",
                     obs_evt.size(), sig(obs_evt), exp_evt.size(), sig(exp_evt));
        end
        n_checks++;
        if (errCount !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL oversize errCount: got %0d, expected %0d", errCount, exp_err);
        end
        $display("oversize: errCount=%0d", errCount);
    endtask

    task automatic test_timeout();
        clear_q();
        send_word(16'h1201);
        send_word(16'h0003);
        send_word(16'h0001);
        exp_evt.push_back(32'h101);
        exp_out.push_back(32'h0001);
        exp_evt.push_back(32'h200);
        exp_err++;
        settle(TIMEOUT + 20);
        n_checks++;
        if (sig(obs_evt) !== sig(exp_evt)) begin
            n_fail++;
            $display("FAIL timeout status: got %0d events (sig %h), expected %0d (sig %h)",
                     obs_evt.size(), sig(obs_evt), exp_evt.size(), sig(exp_evt));
        end
        n_checks++;
        if (errCount !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL timeout errCount: got %0d, expected %0d", errCount, exp_err);
        end
        tx_q.push_back(32'hFFFF);
        tx_q.push_back(32'hFFFF);
        add_frame(8'h12, 8'h3C, 3, 1'b0, 1'b0);
        send_all();
        settle(10);
        n_checks++;
        if (sig(obs_out) !== sig(exp_out) || sig(obs_evt) !== sig(exp_evt)) begin
            n_fail++;
            $display("FAIL timeout_recover: out %0d/%0d words, events %0d/%0d (got/expected)",
                     obs_out.size(), exp_out.size(), obs_evt.size(), exp_evt.size());
        end
        $display("timeout: errCount=%0d, recovery frame events=%0d", errCount, obs_evt.size());
    endtask

    task automatic test_back_to_back_stall();
        clear_q();
        stall = 5;
        add_frame(8'h12, 8'($urandom), 4, 1'b0, 1'b0);
        add_frame(8'hFF, 8'h21, 3, 1'b0, 1'b0);
        send_all();
        settle(20);
        stall = 0;
        n_checks++;
        if (sig(obs_out) !== sig(exp_out)) begin
            n_fail++;
            $display("FAIL stall payload: got %0d words (sig %h), expected %0d words (sig %h)",
                     obs_out.size(), sig(obs_out), exp_out.size(), sig(exp_out));
        end
        n_checks++;
        if (sig(obs_evt) !== sig(exp_evt)) begin
            n_fail++;
            $display("FAIL stall status: got %0d events (sig %h), expected %0d (sig %h)",
                     obs_evt.size(), sig(obs_evt), exp_evt.size(), sig(exp_evt));
        end
        n_checks++;
        if (n_viol !== 0) begin
            n_fail++;
            $display("FAIL stall in_done: %0d accepts during backpressure, expected 0", n_viol);
        end
        $display("back_to_back_stall: %0d payload words", obs_out.size());
    endtask

    task automatic test_random();
        logic [7:0] a, c;
        int         kind, n;
        clear_q();
        for (int f = 0; f < 25; f++) begin
            kind = $urandom_range(0, 9);
            c    = 8'($urandom);
            if (kind < 4)      a = ADDR;
            else if (kind < 6) a = 8'hFF;
            else begin
                do a = 8'($urandom); while (a == ADDR || a == 8'hFF);
            end
            if (a == 8'hFF && c == 8'hFF) c = 8'h00;
            if ($urandom_range(0, 3) == 0) tx_q.push_back(32'hFFFF);
            if ($urandom_range(0, 7) == 0) begin
                add_oversize(a, c, $urandom_range(MAX_SIZE + 1, 200));
            end else begin
                n = $urandom_range(0, MAX_SIZE);
                add_frame(a, c, n, ($urandom_range(0, 3) == 0), 1'b0);
            end
            stall = $urandom_range(0, 3);
            send_all();
        end
        settle(20);
        stall = 0;
        n_checks++;
        if (sig(obs_out) !== sig(exp_out)) begin
            n_fail++;
            $display("FAIL random payload: got %0d words (sig %h), expected %0d words (sig %h)",
                     obs_out.size(), sig(obs_out), exp_out.size(), sig(exp_out));
        end
        n_checks++;
        if (sig(obs_evt) !== sig(exp_evt)) begin
            n_fail++;
            $display("FAIL random status: got %0d events (sig %h), expected %0d (sig %h)",
                     obs_evt.size(), sig(obs_evt), exp_evt.size(), sig(exp_evt));
        end
        n_checks++;
        if (errCount !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL random errCount: got %0d, expected %0d", errCount, exp_err);
        end
        $display("random: %0d payload words, %0d events, errCount=%0d",
                 obs_out.size(), obs_evt.size(), errCount);
    endtask

    task automatic test_reset_mid_frame();
        clear_q();
        stall = 5;
        send_word(16'h1201);
        send_word(16'h0004);
        send_word(16'h1111);
        settle(8);
        send_word(16'h2222);
        @(negedge clk);
        nRst = 1'b0;
        #1;
        n_checks++;
        if ({inBus_done, outBus_request, packetStart, packetEnd, packetOk, cmd, errCount, outBus_data}
            !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_mid_frame outputs: req=%b data=%h cmd=%h err=%h, expected all 0",
                     outBus_request, outBus_data, cmd, errCount);
        end
        settle(2);
        nRst = 1'b1;
        stall = 0;
        exp_err = 0;
        clear_q();
        add_frame(8'h12, 8'h44, 2, 1'b0, 1'b0);
        send_all();
        settle(10);
        n_checks++;
        if (sig(obs_out) !== sig(exp_out) || sig(obs_evt) !== sig(exp_evt)) begin
            n_fail++;
            $display("FAIL reset_recover: out %0d/%0d words, events %0d/%0d (got/expected)",
                     obs_out.size(), exp_out.size(), obs_evt.size(), exp_evt.size());
        end
        n_checks++;
        if (errCount !== 8'(exp_err)) begin
            n_fail++;
            $display("FAIL reset_recover errCount: got %0d, expected %0d", errCount, exp_err);
        end
        $display("reset_mid_frame: recovery frame %0d words", obs_out.size());
    endtask

    task automatic test_protocol();
        n_checks++;
        if (n_both !== 0) begin
            n_fail++;
            $display("FAIL start_end_overlap: %0d cycles with both pulses, expected 0", n_both);
        end
        n_checks++;
        if (n_viol !== 0) begin
            n_fail++;
            $display("FAIL backpressure: %0d accepts while output busy, expected 0", n_viol);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_address_filter();
        test_oversize();
        test_timeout();
        test_back_to_back_stall();
        test_random();
        test_reset_mid_frame();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
